// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package onchip_mem_arb_pkg;

   localparam int ADDR_W = 12;            // 4096 words
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   // Master identifier: 0 = CPU0, 1 = CPU1
   typedef logic master_id_t;

   localparam master_id_t ID_M0 = 1'b0;
   localparam master_id_t ID_M1 = 1'b1;

   // Outstanding read: returns on the cycle after acceptance
   typedef struct packed {
      logic       valid;
      master_id_t id;
   } rd_pend_t;

endpackage

// File: rtl/onchip_memory_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the master not granted last time wins.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: en low forces no grant (used to hold off all masters in reset).
// Ports: clk, reset (sync, active high), req[1:0], en -> grant[1:0] (one-hot or zero).
module rr_arbiter_2
   import onchip_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   // Resets to M1 so that M0 wins the first tie.
   master_id_t last_grant;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == ID_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= ID_M1;
      end else if (grant[0]) begin
         last_grant <= ID_M0;
      end else if (grant[1]) begin
         last_grant <= ID_M1;
      end
   end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port 1-cycle-read RAM between two Avalon-MM masters.
// Latency: accept in request cycle; readdatavalid exactly 1 cycle after accept.
// Backpressure: losing master sees waitrequest for one cycle; all masters wait in reset.
// Ports: clk, reset (sync, active high); m0_*/m1_* Avalon-MM slave ports;
//        mem_* to RAM s1 (address/byteenable/chipselect/write/writedata/clken, readdata in);
//        err_rw sticky flag for simultaneous read+write from a master.
module onchip_memory_arbiter #(
   parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W,
   parameter int DATA_W = onchip_mem_arb_pkg::DATA_W,
   parameter int BE_W   = onchip_mem_arb_pkg::BE_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,

   output logic              err_rw
);

   import onchip_mem_arb_pkg::*;

   logic [1:0] req;
   logic [1:0] grant;
   logic       rd_acc;
   rd_pend_t   rd_pend;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   rr_arbiter_2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .en    (~reset),
      .grant (grant)
   );

   assign m0_waitrequest = req[0] & ~grant[0];
   assign m1_waitrequest = req[1] & ~grant[1];

   // Address/data mux; the idle default to m0 is harmless since chipselect is low.
   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      if (grant[1]) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end
   end

   assign mem_chipselect = |grant;
   assign mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
   assign mem_clken      = 1'b1;

   // Read+write together is executed as a write, so it never produces read data.
   assign rd_acc = (grant[0] & m0_read & ~m0_write) | (grant[1] & m1_read & ~m1_write);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= '0;
      end else begin
         rd_pend.valid <= rd_acc;
         rd_pend.id    <= grant[1] ? ID_M1 : ID_M0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_rw <= 1'b0;
      end else if ((m0_read & m0_write) | (m1_read & m1_write)) begin
         err_rw <= 1'b1;
      end
   end

   // Gating with ~reset drops a return that lands in a reset cycle.
   assign m0_readdatavalid = rd_pend.valid & (rd_pend.id == ID_M0) & ~reset;
   assign m1_readdatavalid = rd_pend.valid & (rd_pend.id == ID_M1) & ~reset;

   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: directed steps followed by a randomized run
// checked against a request/grant/memory reference model.
// Includes a behavioural 4096x32 RAM with registered address and unregistered q.
module tb_onchip_memory_arbiter;

   localparam int NRAND = 300;

   logic        clk;
   logic        reset;

   logic [11:0] m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;

   logic [11:0] m1_address;
   logic [3:0]  m1_byteenable;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;

   logic [11:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic        err_rw;

   int n_cmp = 0;
   int n_err = 0;

   onchip_memory_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata),
      .err_rw           (err_rw)
   );

   // RAM model
   logic [31:0] ram [0:4095];
   logic [11:0] ram_addr_q;

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         ram_addr_q <= mem_address;
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
         end
      end
   end

   assign mem_readdata = ram[ram_addr_q];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic rd, input logic wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
   endtask

   task automatic idle();
      m0_read = 1'b0; m0_write = 1'b0;
      m1_read = 1'b0; m1_write = 1'b0;
   endtask

   // Reference model state for the randomized run
   logic [31:0] ref_mem [16];
   logic        exp_last;   // id of the master that won most recently
   logic        pend_v;
   logic        pend_id;
   logic [31:0] pend_d;
   logic        exp_err;

   task automatic drive_rand(input int m);
      int          kind;
      logic        rd, wr;
      logic [11:0] a;
      kind = int'($urandom_range(0, 15));
      rd = (kind >= 6 && kind <= 10) || kind == 15;
      wr = (kind >= 11);
      a  = 12'($urandom_range(0, 15));
      if (m == 0) set_m0(rd, wr, a, 4'($urandom), $urandom);
      else        set_m1(rd, wr, a, 4'($urandom), $urandom);
   endtask

   task automatic rand_step(input bit drive);
      logic        r0, r1, g0, g1, rd, wr;
      logic [3:0]  a;
      logic [3:0]  be;
      logic [31:0] d;
      if (drive) begin
         drive_rand(0);
         drive_rand(1);
      end else begin
         idle();
      end
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      // Tie goes to whoever did not win last time
      g0 = r0 && (!r1 || exp_last);
      g1 = r1 && !g0;
      chk1("rnd_wait0", m0_waitrequest, r0 && !g0);
      chk1("rnd_wait1", m1_waitrequest, r1 && !g1);
      chk1("rnd_cs", mem_chipselect, g0 || g1);
      chk1("rnd_rdv0", m0_readdatavalid, pend_v && !pend_id);
      chk1("rnd_rdv1", m1_readdatavalid, pend_v && pend_id);
      if (pend_v) chk32("rnd_rdata", pend_id ? m1_readdata : m0_readdata, pend_d);
      chk1("rnd_err", err_rw, exp_err);

      pend_v = 1'b0;
      if (g0 || g1) begin
         rd = g1 ? m1_read : m0_read;
         wr = g1 ? m1_write : m0_write;
         a  = g1 ? m1_address[3:0] : m0_address[3:0];
         be = g1 ? m1_byteenable : m0_byteenable;
         d  = g1 ? m1_writedata : m0_writedata;
         chk1("rnd_mwr", mem_write, wr);
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
         end else begin
            pend_v  = rd;
            pend_id = g1;
            pend_d  = ref_mem[a];
         end
         exp_last = g1;
      end
      exp_err = exp_err || (m0_read && m0_write) || (m1_read && m1_write);
      tick();
   endtask

   initial begin
      logic [31:0] d;
      reset = 1'b1;
      set_m0(1'b0, 1'b0, 12'h000, 4'hF, 32'h0);
      set_m1(1'b0, 1'b0, 12'h000, 4'hF, 32'h0);
      tick();
      // Requester held off during reset
      set_m0(1'b1, 1'b0, 12'h000, 4'hF, 32'h0);
      @(negedge clk);
      chk1("rst_wait0", m0_waitrequest, 1'b1);
      chk1("rst_cs", mem_chipselect, 1'b0);
      chk1("rst_rdv0", m0_readdatavalid, 1'b0);
      chk1("rst_rdv1", m1_readdatavalid, 1'b0);
      chk1("rst_err", err_rw, 1'b0);
      chk1("rst_clken", mem_clken, 1'b1);
      tick();
      idle();
      tick();
      reset = 1'b0;

      // Full-word write then read-back on m0
      set_m0(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      chk1("wr_wait0", m0_waitrequest, 1'b0);
      chk1("wr_mwr", mem_write, 1'b1);
      tick();
      set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      @(negedge clk);
      chk1("rd_wait0", m0_waitrequest, 1'b0);
      chk1("rd_rdv0_early", m0_readdatavalid, 1'b0);
      tick();
      idle();
      @(negedge clk);
      chk1("rd_rdv0", m0_readdatavalid, 1'b1);
      chk32("rd_data0", m0_readdata, 32'hDEADBEEF);
      chk1("rd_rdv1", m1_readdatavalid, 1'b0);
      tick();
      @(negedge clk);
      chk1("rd_rdv0_once", m0_readdatavalid, 1'b0);

      // Byte-lane write on m1
      set_m1(1'b0, 1'b1, 12'h020, 4'hF, 32'h11223344);
      tick();
      set_m1(1'b0, 1'b1, 12'h020, 4'h2, 32'h0000AB00);
      tick();
      set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
      tick();
      idle();
      @(negedge clk);
      chk1("be_rdv1", m1_readdatavalid, 1'b1);
      chk32("be_data1", m1_readdata, 32'h1122AB44);
      chk1("be_rdv0", m0_readdatavalid, 1'b0);
      tick();

      // Continuous reads from both masters starting at reset release
      set_m0(1'b0, 1'b1, 12'h001, 4'hF, 32'hA1A1A1A1);
      tick();
      set_m0(1'b0, 1'b1, 12'h002, 4'hF, 32'hB2B2B2B2);
      tick();
      reset = 1'b1;
      set_m0(1'b1, 1'b0, 12'h001, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 12'h002, 4'hF, 32'h0);
      @(negedge clk);
      chk1("rr_rst_wait0", m0_waitrequest, 1'b1);
      chk1("rr_rst_wait1", m1_waitrequest, 1'b1);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk1("rr_wait0", m0_waitrequest, (k % 2) != 0);
         chk1("rr_wait1", m1_waitrequest, (k % 2) == 0);
         if (k > 0) begin
            chk1("rr_rdv0", m0_readdatavalid, (k % 2) != 0);
            chk1("rr_rdv1", m1_readdatavalid, (k % 2) == 0);
            if ((k % 2) != 0) chk32("rr_data0", m0_readdata, 32'hA1A1A1A1);
            else              chk32("rr_data1", m1_readdata, 32'hB2B2B2B2);
         end
         tick();
      end
      idle();
      @(negedge clk);
      chk1("rr_tail_rdv1", m1_readdatavalid, 1'b1);
      chk32("rr_tail_data1", m1_readdata, 32'hB2B2B2B2);
      chk1("rr_tail_rdv0", m0_readdatavalid, 1'b0);
      tick();

      // Read and write together behaves as a write and sets err_rw
      set_m0(1'b1, 1'b1, 12'h030, 4'hF, 32'h00000005);
      @(negedge clk);
      chk1("rw_err_before", err_rw, 1'b0);
      chk1("rw_mwr", mem_write, 1'b1);
      tick();
      idle();
      @(negedge clk);
      chk1("rw_rdv0", m0_readdatavalid, 1'b0);
      chk1("rw_err", err_rw, 1'b1);
      chk32("rw_mem", ram[12'h030], 32'h00000005);
      tick();
      tick();

      // Read accepted right before reset: its return is dropped
      set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
      @(negedge clk);
      chk1("rr2_wait1", m1_waitrequest, 1'b0);
      chk1("rw_err_sticky", err_rw, 1'b1);
      tick();
      reset = 1'b1;
      set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
      @(negedge clk);
      chk1("rstmid_rdv1", m1_readdatavalid, 1'b0);
      chk1("rstmid_rdv0", m0_readdatavalid, 1'b0);
      tick();
      @(negedge clk);
      chk1("rstmid_err", err_rw, 1'b0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk1("rstmid_tie_wait0", m0_waitrequest, 1'b0);
      chk1("rstmid_tie_wait1", m1_waitrequest, 1'b1);
      tick();
      idle();
      @(negedge clk);
      chk1("rstmid_rdv0", m0_readdatavalid, 1'b1);
      chk32("rstmid_data0", m0_readdata, 32'hDEADBEEF);
      tick();

      // Idle bus
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk1("idle_cs", mem_chipselect, 1'b0);
         chk1("idle_mwr", mem_write, 1'b0);
         chk1("idle_wait0", m0_waitrequest, 1'b0);
         chk1("idle_wait1", m1_waitrequest, 1'b0);
         chk1("idle_clken", mem_clken, 1'b1);
         tick();
      end

      // Randomized run: preload words 0..15 through m0, then random traffic
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         set_m0(1'b0, 1'b1, 12'(i), 4'hF, d);
         ref_mem[i] = d;
         @(negedge clk);
         chk1("pre_wait0", m0_waitrequest, 1'b0);
         tick();
      end
      idle();
      exp_last = 1'b0;
      pend_v   = 1'b0;
      pend_id  = 1'b0;
      pend_d   = 32'h0;
      exp_err  = 1'b0;
      for (int i = 0; i <= NRAND; i++) begin
         rand_step(i < NRAND);
      end
      for (int i = 0; i < 16; i++) begin
         chk32("rnd_final_mem", ram[12'(i)], ref_mem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/onchip_memory_arbiter.md
Name: onchip_memory_arbiter

Overview:
- Shares one single-port 4096x32 on-chip RAM between two Avalon-MM masters (CPU0, CPU1) of the two-processor system.
- The RAM has 1-cycle read latency (registered address, unregistered q).
- Round-robin arbitration issues at most one access per cycle; the block drives per-master waitrequest and readdatavalid.
- Sits between the two CPU data masters and the RAM's s1 interface.

Parameters:
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  high = master 0 request not accepted this cycle
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set as m0_*, for master 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM readdata
- err_rw  out  1  sticky flag: a master asserted read and write together

Behaviour:
- Request: reqN = mN_read | mN_write.
- Grant, combinational each cycle:
  - Only one master requesting: it wins.
  - Both requesting: the master that was not last granted wins.
  - No request: no grant; mem_chipselect = 0 and mem_write = 0.
- last_grant register: updated on every cycle with a grant. Reset value = 1, so m0 wins the first tie.
- mem_* address, byteenable, writedata and write are muxed combinationally from the granted master. mem_chipselect = any grant; mem_write = granted mWrite.
- mN_waitrequest = reqN & ~grantN. Acceptance = reqN & ~waitrequest, completing in the same cycle.
- During reset: no grants, so every requesting master sees waitrequest = 1.
- Writes: single cycle; the RAM captures on the same clk edge. No response.
- Reads: pending register rd_pend (valid bit + master id) set on the accepting edge.
  - Next cycle: mN_readdatavalid = 1 for the recorded master only, mN_readdata = mem_readdata.
  - mN_readdata is driven from mem_readdata unconditionally; it is meaningful only while readdatavalid.
- Read latency = 1 cycle after acceptance. Back-to-back accepted reads (same or alternating masters) give consecutive readdatavalid pulses with no bubble.
- Read and write asserted together: treated as a write; err_rw is set and held until reset.
- Fairness: with both masters requesting continuously, grants alternate strictly every cycle. Neither master waits more than 1 cycle.
- Reset mid-operation: rd_pend valid, last_grant = 1 and err_rw are cleared on the reset edge.
  - A read accepted on the edge before reset has its readdatavalid suppressed if reset is high in the return cycle.
- Reset values: both readdatavalid = 0, err_rw = 0, rd_pend valid = 0, mem_clken = 1. mem_chipselect = 0 while no requests.
- Address and byteenable are passed through unmodified; no range checking (width fixes the range at 0..4095).

Decomposition:
- Package onchip_mem_arb_pkg:
  - ADDR_W/DATA_W/BE_W constants
  - master-id type (1 bit)
  - read-pending struct (valid, id)
- One sub-module, rr_arbiter_2:
  - inputs req[1:0] and accept-enable
  - outputs one-hot grant[1:0]
  - contains the last_grant register
- Muxing and read-return tracking stay in the top.

Test Plan:
- Write m0 0x010=0xDEADBEEF, be=0xF; then m0 read 0x010 -> waitrequest 0 on both cycles, m0_readdatavalid exactly 1 cycle after the read is accepted, readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Byte write m1 0x020 be=0x2 data=0x0000AB00 over prior 0x11223344; read back -> 0x1122AB44.
- Both masters read continuously from reset (m0 addr 0x001, m1 addr 0x002) for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each waitrequest high on alternate cycles; valid pulses alternate with matching data.
- m0 asserts read and write together at 0x030 data 0x5 -> memory written with 0x5, no readdatavalid, err_rw=1 and stays 1 until reset.
- m1 read accepted, reset asserted the next cycle -> m1_readdatavalid stays 0, err_rw=0; the first tie after reset is granted to m0.
- No requests for 10 cycles -> mem_chipselect=0, mem_write=0, both waitrequest=0, mem_clken=1.
